// File: rtl/mem_master_pkg.sv
// Shared widths, logic levels and access-size encodings for the memory master slice.
package mem_master_pkg;

    localparam int WIDTH = 32;
    localparam int LANES = WIDTH / 8;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Bytes touched by an access; the illegal size reports 0 and is rejected separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load extract/extend and store merge into the
// read word, selected by access size, byte offset and signedness.
module mem_lane_unit
    import mem_master_pkg::*;
(
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_rdata,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_load_data,
    output logic [WIDTH-1:0] o_store_word
);

    logic [7:0]  w_rd_lane [LANES];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_hit;
            logic [7:0] w_src;

            assign w_rd_lane[gi] = i_rdata[8*gi +: 8];

            // Store data is right-aligned, so a halfword feeds lanes from its low/high byte.
            always_comb begin
                w_hit = LOW;
                w_src = i_wdata[8*gi +: 8];
                case (i_size)
                    SZ_B: begin
                        w_hit = (i_addr_lo == LANE);
                        w_src = i_wdata[7:0];
                    end
                    SZ_H: begin
                        w_hit = (i_addr_lo[1] == LANE[1]);
                        w_src = i_wdata[8*(gi%2) +: 8];
                    end
                    SZ_W:    w_hit = HIGH;
                    default: w_hit = LOW;
                endcase
            end

            assign o_store_word[8*gi +: 8] = w_hit ? w_src : w_rd_lane[gi];
        end
    endgenerate

    assign w_byte = w_rd_lane[i_addr_lo];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = '0;
        case (i_size)
            SZ_B:    o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_H:    o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SZ_W:    o_load_data = i_rdata;
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_master.sv
// CPU-side load/store master for a word-wide memory: validates requests,
// reads for loads, and does read-modify-write for sub-word stores.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             MemRd,
    output logic             MemWr,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] W_data,
    input  logic [WIDTH-1:0] R_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [1:0]       r_addr_lo;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic             r_err;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_wword;

    logic             w_accept;
    logic             w_misalign;
    logic             w_err;
    logic [WIDTH:0]   w_end;
    logic [WIDTH-1:0] w_load_data;
    logic [WIDTH-1:0] w_store_word;

    // One extra bit so addresses near the top of the 32-bit space cannot wrap past the check.
    assign w_end      = {1'b0, req_addr} + (WIDTH+1)'(size_bytes(req_size));
    assign w_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign w_err      = (req_size == SZ_X) || w_misalign || (w_end > (WIDTH+1)'(MEM_BYTES));
    assign w_accept   = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_state_next = r_state;
        req_ready    = LOW;
        rsp_valid    = LOW;
        rsp_err      = LOW;
        MemRd        = LOW;
        MemWr        = LOW;
        case (r_state)
            S_IDLE: begin
                req_ready = HIGH;
                if (req_valid) begin
                    if (w_err)
                        w_state_next = S_RESP;
                    else if (req_we && (req_size == SZ_W))
                        w_state_next = S_WR;
                    else
                        w_state_next = S_RD;
                end
            end
            S_RD: begin
                MemRd        = HIGH;
                w_state_next = r_we ? S_WR : S_RESP;
            end
            S_WR: begin
                MemWr        = HIGH;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid    = HIGH;
                rsp_err      = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= LOW;
            r_size    <= SZ_B;
            r_signed  <= LOW;
            r_addr_lo <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= LOW;
            r_rdata   <= '0;
            r_wword   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we      <= req_we;
                r_size    <= req_size;
                r_signed  <= req_signed;
                r_addr_lo <= req_addr[1:0];
                r_addr    <= {req_addr[WIDTH-1:2], 2'b00};
                r_wdata   <= req_wdata;
                r_err     <= w_err;
                r_rdata   <= '0;
                if (req_we && (req_size == SZ_W) && !w_err)
                    r_wword <= req_wdata;
            end
            // RD serves both loads and the read half of a sub-word store.
            if (r_state == S_RD) begin
                if (r_we)
                    r_wword <= w_store_word;
                else
                    r_rdata <= w_load_data;
            end
        end
    end

    assign addr      = r_addr;
    assign W_data    = r_wword;
    assign rsp_rdata = r_rdata;

    mem_lane_unit u_lane (
        .i_size       (r_size),
        .i_addr_lo    (r_addr_lo),
        .i_signed     (r_signed),
        .i_rdata      (R_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] addr;
    logic [31:0] W_data;
    logic [31:0] R_data;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_rsp = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;

    mem_master #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .addr       (addr),
        .W_data     (W_data),
        .R_data     (R_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (MemWr) mem[addr[9:2]] = W_data;
    end

    assign R_data = MemRd ? mem[addr[9:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (MemRd) n_rd++;
            if (MemWr) begin
                n_wr++;
                last_wdata = W_data;
                last_waddr = addr;
            end
            if (MemRd && MemWr) begin
                n_checks++;
                n_errors++;
                $display("FAIL strobe_overlap: MemRd=1 MemWr=1 at cycle %0d, expected never both", cyc);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected no response", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_rsp++;
                    $display("rsp %0d [%s]: rdata=%h err=%b cycle=%0d", n_rsp, e.tag, rsp_rdata, rsp_err, cyc);
                    chk({e.tag, " rdata"}, rsp_rdata, e.d);
                    chk({e.tag, " err"}, {31'b0, rsp_err}, {31'b0, e.e});
                    chk({e.tag, " latency"}, cyc, e.due);
                    chk({e.tag, " ready_in_resp"}, {31'b0, req_ready}, 32'h0);
                end
            end
        end
    end

    // lat < 0: no response is expected (operation will be cut by reset).
    task automatic issue(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int lat);
        int g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            chk({tag, " ready_timeout"}, {31'b0, req_ready}, 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (lat >= 0) begin
            e.tag = tag; e.d = exp_d; e.e = exp_e; e.due = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, g;
        int acc [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        exp_t e;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        mem[8'h41] = 32'h11223344;
        mem[8'hFF] = 32'h0BADF00D;

        // Reset values, sampled while rst_n is held low.
        #2 rst_n = 1'b0;
        #1;
        chk("rst req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst rsp_err",   {31'b0, rsp_err},   32'h0);
        chk("rst MemRd",     {31'b0, MemRd},     32'h0);
        chk("rst MemWr",     {31'b0, MemWr},     32'h0);
        chk("rst addr",      addr,               32'h0);
        chk("rst W_data",    W_data,             32'h0);
        chk("rst rsp_rdata", rsp_rdata,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads from 0x8899AABB
        issue("lb_s_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        drain();
        issue("lh_u_100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2);
        drain();
        issue("lw_100",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2);
        drain();
        issue("lb_u_102", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h00000099, 1'b0, 2);
        drain();
        issue("lh_s_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2);
        drain();

        // Byte store RMW
        rd0 = n_rd; wr0 = n_wr;
        issue("sb_101", 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 32'h0, 1'b0, 3);
        drain();
        chk("sb_101 rd_cycles", n_rd - rd0, 1);
        chk("sb_101 wr_cycles", n_wr - wr0, 1);
        chk("sb_101 W_data",    last_wdata, 32'h88995ABB);
        chk("sb_101 addr",      last_waddr, 32'h00000100);
        issue("lw_100_after_sb", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h88995ABB, 1'b0, 2);
        drain();

        // Halfword store into upper pair, word store
        issue("sh_106", 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234CAFE, 32'h0, 1'b0, 3);
        drain();
        issue("lw_104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCAFE3344, 1'b0, 2);
        drain();
        rd0 = n_rd; wr0 = n_wr;
        issue("sw_108", 1'b1, 2'b10, 1'b0, 32'h108, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        drain();
        chk("sw_108 rd_cycles", n_rd - rd0, 0);
        chk("sw_108 wr_cycles", n_wr - wr0, 1);
        issue("lw_108", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        drain();

        // Error requests: no strobes, response one cycle after acceptance
        rd0 = n_rd; wr0 = n_wr;
        issue("err_sw_102", 1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 32'h0, 1'b1, 1);
        drain();
        issue("err_lh_001", 1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 32'h0, 1'b1, 1);
        drain();
        issue("err_lw_3FE", 1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, 32'h0, 1'b1, 1);
        drain();
        issue("err_size11", 1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 1);
        drain();
        issue("err_lb_400", 1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        drain();
        chk("err rd_cycles", n_rd - rd0, 0);
        chk("err wr_cycles", n_wr - wr0, 0);

        // Top-of-memory accesses that just fit
        issue("lw_3FC", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, 2);
        drain();
        issue("lh_u_3FE", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, 32'h00000BAD, 1'b0, 2);
        drain();

        // Reset during the WR cycle of a byte store
        issue("sb_10D_cut", 1'b1, 2'b00, 1'b0, 32'h10D, 32'h00000077, 32'h0, 1'b0, -1);
        g = 0;
        while (!MemWr && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("cut reached_WR", {31'b0, MemWr}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("cut MemWr",     {31'b0, MemWr},     32'h0);
        chk("cut req_ready", {31'b0, req_ready}, 32'h1);
        chk("cut rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("cut W_data",    W_data,             32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("cut ready_after", {31'b0, req_ready}, 32'h1);
        issue("lw_100_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h88995ABB, 1'b0, 2);
        drain();

        // Back-to-back loads with req_valid held high
        b2b_addr[0] = 32'h100; b2b_data[0] = 32'h88995ABB;
        b2b_addr[1] = 32'h104; b2b_data[1] = 32'hCAFE3344;
        b2b_addr[2] = 32'h108; b2b_data[2] = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) acc[k] = -100;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            g = 0;
            while (!req_ready && g < 10) begin
                @(negedge clk);
                g++;
            end
            if (req_ready) begin
                req_addr = b2b_addr[k];
                acc[k]   = cyc;
                e.tag = "b2b"; e.d = b2b_data[k]; e.e = 1'b0; e.due = cyc + 2;
                sb.push_back(e);
            end
            @(negedge clk);
            if (k < 2) chk("b2b ready_low_after_accept", {31'b0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        drain();
        chk("b2b gap01", acc[1] - acc[0], 3);
        chk("b2b gap12", acc[2] - acc[1], 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
